back_proj: RTL and testbench
============================

Name: back_proj

Overview:
- Inverse of the projection stage: converts a raster-ordered depth stream into a 3D point cloud using the pinhole model.
  - x = (u − cx)·d / fx
  - y = (v − cy)·d / fy
  - z = d
- Pixel coordinates (u, v) come from internal raster counters. Division is done by multiplying with host-programmed reciprocals 1/fx and 1/fy.
- Sits between the depth-frame reader and the transform/projection pipeline; output cloud format is Q(MUL) signed.

Parameters:
- H_SIZE_BW, 10, column counter width.
- V_SIZE_BW, 9, row counter width.
- DEPTH_BW, 16, unsigned depth sample width (raw units).
- MUL, 8, fractional bits of cx/cy and of the output cloud.
- INV_BW, 24, width of unsigned reciprocal registers; all bits are fractional.
- CLOUD_BW, 32, signed output coordinate width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  depth sample valid
- i_frame_start  in  1  marks first pixel of frame; qualified by i_valid
- i_depth  in  DEPTH_BW  depth sample
- o_ready  out  1  input accepted when i_valid & o_ready
- r_width  in  H_SIZE_BW  frame width in pixels
- r_height  in  V_SIZE_BW  frame height in pixels
- r_cx  in  H_SIZE_BW+MUL  principal point x, unsigned Q(MUL)
- r_cy  in  V_SIZE_BW+MUL  principal point y, unsigned Q(MUL)
- r_inv_fx  in  INV_BW  round(2^INV_BW / fx)
- r_inv_fy  in  INV_BW  round(2^INV_BW / fy)
- i_ready  in  1  downstream ready
- o_valid  out  1  output beat valid
- o_point_valid  out  1  point usable (depth nonzero and in range)
- o_cloud_x  out  CLOUD_BW  signed Q(MUL)
- o_cloud_y  out  CLOUD_BW  signed Q(MUL)
- o_cloud_z  out  CLOUD_BW  signed Q(MUL), equals d << MUL
- o_idx_x  out  H_SIZE_BW  u of this beat
- o_idx_y  out  V_SIZE_BW  v of this beat
- o_frame_end  out  1  beat is pixel (r_width−1, r_height−1)

Behaviour:
- Reset: all outputs 0, counters u = v = 0, pipeline valids cleared.
- Handshake:
  - pipe_en = i_ready; o_ready = i_ready.
  - Pipeline stages advance only when pipe_en = 1. When i_ready = 0, all stage registers and outputs hold.
  - Latency is 3 enabled cycles from accept to o_valid. Throughput is 1 beat/cycle.
- Raster counters advance on each accept:
  - Accept with i_frame_start = 1: beat uses (0,0); counters become (1,0).
  - Otherwise the beat uses the current (u,v).
  - u wraps to 0 at r_width−1 and v increments. v wraps to 0 after (r_width−1, r_height−1).
  - i_frame_start mid-frame forces (0,0): frame resync, no error flag.
- Stage 1:
  - du = (u<<MUL) − r_cx, dv = (v<<MUL) − r_cy, signed with one extra bit.
  - Register d and the zero flag (d == 0).
- Stage 2: pu = du·d, pv = dv·d (full-width signed).
- Stage 3:
  - x = (pu·r_inv_fx) >>> INV_BW, y = (pv·r_inv_fy) >>> INV_BW.
  - Arithmetic shift, truncation toward −inf.
  - Saturate to signed CLOUD_BW range (max 0x7FFF_FFFF, min 0x8000_0000 at default).
- Invalid depth: d == 0 gives o_point_valid = 0 and o_cloud_x/y/z = 0, but o_valid = 1; the raster position is still consumed.
- o_idx_x, o_idx_y and o_frame_end travel in the pipeline alongside their beat.
- r_* registers are quasi-static; changing them mid-frame gives undefined points but no protocol corruption.
- Reset mid-frame: pipeline flushed, counters return to (0,0), o_valid = 0 on the next edge.

Optional Feature:
- Macro BACK_PROJ_DEPTH_RANGE_EN. When defined, adds ports r_depth_min and r_depth_max (DEPTH_BW each).
  - A beat with d < r_depth_min or d > r_depth_max is treated exactly like d == 0: o_point_valid = 0, coordinates 0.
- When undefined, those ports are absent and only d == 0 invalidates a point.

Test Plan:
- Reset with r_width=640, r_height=480, r_cx=320<<8, r_cy=240<<8, r_inv_fx=r_inv_fy=2^15 (fx=512). Then accept pixel (0,0) with d=1024, i_frame_start=1, i_ready=1 -> 3 cycles later o_valid=1, o_cloud_x=−640<<8, o_cloud_y=−480<<8, o_cloud_z=1024<<8, o_point_valid=1.
- Stream a full 640×480 frame with d=1 everywhere -> exactly 307200 o_valid beats; o_frame_end=1 only on beat (639,479); the next accept without i_frame_start is at (0,0).
- d=0 at pixel (5,7) -> o_valid=1, o_point_valid=0, x=y=z=0, o_idx_x=5, o_idx_y=7.
- Hold i_ready=0 for 4 cycles with 3 beats in flight -> outputs frozen, o_ready=0. On release, beats emerge in order with no loss or duplication.
- r_inv_fx=2^24−1, u=639, d=65535 -> o_cloud_x saturates to 0x7FFF_FFFF.
- i_frame_start asserted at pixel 100 of row 3 -> that beat reports (0,0). With BACK_PROJ_DEPTH_RANGE_EN, min=100, max=4000: d=99 and d=4001 -> o_point_valid=0; d=100 -> 1.

Source files
------------

// File: rtl/back_proj.sv
// back_proj: back-projects a raster-ordered depth stream into a 3D point cloud
// with the pinhole model.
//   x = (u - cx) * d / fx,  y = (v - cy) * d / fy,  z = d
// Division by fx/fy is a multiply by the host-programmed reciprocals
// r_inv_fx / r_inv_fy (all INV_BW bits fractional). Output coordinates are
// signed Q(MUL) values, saturated to CLOUD_BW bits.
// The pipeline has three register stages, and i_ready stalls all of them.
// Optional build macro BACK_PROJ_DEPTH_RANGE_EN adds the r_depth_min and
// r_depth_max ports. A depth outside that range is treated like a zero depth.
module back_proj #(
  parameter int H_SIZE_BW = 10,
  parameter int V_SIZE_BW = 9,
  parameter int DEPTH_BW  = 16,
  parameter int MUL       = 8,
  parameter int INV_BW    = 24,
  parameter int CLOUD_BW  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_frame_start,
  input  logic [DEPTH_BW-1:0]        i_depth,
  output logic                       o_ready,
  input  logic [H_SIZE_BW-1:0]       r_width,
  input  logic [V_SIZE_BW-1:0]       r_height,
  input  logic [H_SIZE_BW+MUL-1:0]   r_cx,
  input  logic [V_SIZE_BW+MUL-1:0]   r_cy,
  input  logic [INV_BW-1:0]          r_inv_fx,
  input  logic [INV_BW-1:0]          r_inv_fy,
`ifdef BACK_PROJ_DEPTH_RANGE_EN
  input  logic [DEPTH_BW-1:0]        r_depth_min,
  input  logic [DEPTH_BW-1:0]        r_depth_max,
`endif
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic                       o_point_valid,
  output logic signed [CLOUD_BW-1:0] o_cloud_x,
  output logic signed [CLOUD_BW-1:0] o_cloud_y,
  output logic signed [CLOUD_BW-1:0] o_cloud_z,
  output logic [H_SIZE_BW-1:0]       o_idx_x,
  output logic [V_SIZE_BW-1:0]       o_idx_y,
  output logic                       o_frame_end
);

  // Signed pixel offset width: the wider of the u/v Q(MUL) fields, plus a sign bit.
  localparam int CW = ((H_SIZE_BW > V_SIZE_BW) ? H_SIZE_BW : V_SIZE_BW) + MUL + 1;
  // Width of offset * depth, where depth is zero-extended to a signed value.
  localparam int PW = CW + DEPTH_BW + 1;
  // Width of (offset * depth) * reciprocal, before the shift.
  localparam int QW = PW + INV_BW + 1;

  logic pipe_en;
  logic accept;

  assign pipe_en = i_ready;
  assign o_ready = i_ready;
  assign accept  = i_valid & i_ready;

  // Clamp a wide signed value to the signed CLOUD_BW range.
  function automatic logic signed [CLOUD_BW-1:0] sat_cloud(input logic signed [QW-1:0] v);
    if ((&v[QW-1:CLOUD_BW-1]) || !(|v[QW-1:CLOUD_BW-1])) begin
      return v[CLOUD_BW-1:0];
    end else if (v[QW-1]) begin
      return {1'b1, {(CLOUD_BW-1){1'b0}}};
    end else begin
      return {1'b0, {(CLOUD_BW-1){1'b1}}};
    end
  endfunction

  // ---------------------------------------------------------------- raster
  logic [H_SIZE_BW-1:0] u_q, u_d, pix_u;
  logic [V_SIZE_BW-1:0] v_q, v_d, pix_v;
  logic                 pix_end;

  // Pick the pixel of this beat (frame_start forces 0,0) and advance the raster.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pix_u = i_frame_start ? '0 : u_q;
    pix_v = i_frame_start ? '0 : v_q;
    u_d   = u_q;
    v_d   = v_q;
    pix_end = (pix_u == r_width - H_SIZE_BW'(1)) && (pix_v == r_height - V_SIZE_BW'(1));
    if (accept) begin
      if (pix_u == r_width - H_SIZE_BW'(1)) begin
        u_d = '0;
        v_d = (pix_v == r_height - V_SIZE_BW'(1)) ? '0 : pix_v + V_SIZE_BW'(1);
      end else begin
        u_d = pix_u + H_SIZE_BW'(1);
        v_d = pix_v;
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      u_q <= '0;
      v_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      u_q <= u_d;
      v_q <= v_d;
    end
  end

  // --------------------------------------------------------------- stage 1
  logic [CW-1:0]        u_fix, v_fix, cx_fix, cy_fix;
  logic signed [CW-1:0] du_d, dv_d;
  logic                 bad_d;

  assign u_fix  = CW'({pix_u, {MUL{1'b0}}});
  assign v_fix  = CW'({pix_v, {MUL{1'b0}}});
  assign cx_fix = CW'(r_cx);
  assign cy_fix = CW'(r_cy);
  assign du_d   = $signed(u_fix - cx_fix);
  assign dv_d   = $signed(v_fix - cy_fix);

`ifdef BACK_PROJ_DEPTH_RANGE_EN
  assign bad_d = (i_depth == '0) || (i_depth < r_depth_min) || (i_depth > r_depth_max);
`else
  assign bad_d = (i_depth == '0);
`endif

  logic                 s1_valid_q, s1_bad_q, s1_end_q;
  logic signed [CW-1:0] s1_du_q, s1_dv_q;
  logic [DEPTH_BW-1:0]  s1_d_q;
  logic [H_SIZE_BW-1:0] s1_u_q;
  logic [V_SIZE_BW-1:0] s1_v_q;

  // Stage 1: register the principal-point offsets, the depth and the invalid flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bad_q   <= 1'b0;
      s1_end_q   <= 1'b0;
      s1_du_q    <= '0;
      s1_dv_q    <= '0;
      s1_d_q     <= '0;
      s1_u_q     <= '0;
      s1_v_q     <= '0;
    end else if (pipe_en) begin
      s1_valid_q <= i_valid;
      s1_bad_q   <= bad_d;
      s1_end_q   <= pix_end;
      s1_du_q    <= du_d;
      s1_dv_q    <= dv_d;
      s1_d_q     <= i_depth;
      s1_u_q     <= pix_u;
      s1_v_q     <= pix_v;
    end
  end

  // --------------------------------------------------------------- stage 2
  logic signed [PW-1:0] pu_d, pv_d;

  assign pu_d = PW'(s1_du_q) * PW'($signed({1'b0, s1_d_q}));
  assign pv_d = PW'(s1_dv_q) * PW'($signed({1'b0, s1_d_q}));

  logic                 s2_valid_q, s2_bad_q, s2_end_q;
  logic signed [PW-1:0] s2_pu_q, s2_pv_q;
  logic [DEPTH_BW-1:0]  s2_d_q;
  logic [H_SIZE_BW-1:0] s2_u_q;
  logic [V_SIZE_BW-1:0] s2_v_q;

  // Stage 2: register the offset * depth products.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_bad_q   <= 1'b0;
      s2_end_q   <= 1'b0;
      s2_pu_q    <= '0;
      s2_pv_q    <= '0;
      s2_d_q     <= '0;
      s2_u_q     <= '0;
      s2_v_q     <= '0;
    end else if (pipe_en) begin
      s2_valid_q <= s1_valid_q;
      s2_bad_q   <= s1_bad_q;
      s2_end_q   <= s1_end_q;
      s2_pu_q    <= pu_d;
      s2_pv_q    <= pv_d;
      s2_d_q     <= s1_d_q;
      s2_u_q     <= s1_u_q;
      s2_v_q     <= s1_v_q;
    end
  end

  // --------------------------------------------------------------- stage 3
  logic signed [QW-1:0]       qx, qy, sx, sy;
  logic signed [CLOUD_BW-1:0] x_d, y_d, z_d;

  assign qx  = QW'(s2_pu_q) * QW'($signed({1'b0, r_inv_fx}));
  assign qy  = QW'(s2_pv_q) * QW'($signed({1'b0, r_inv_fy}));
  // Arithmetic shift, so the result is rounded toward minus infinity.
  assign sx  = qx >>> INV_BW;
  assign sy  = qy >>> INV_BW;
  assign x_d = s2_bad_q ? '0 : sat_cloud(sx);
  assign y_d = s2_bad_q ? '0 : sat_cloud(sy);
  assign z_d = s2_bad_q ? '0 : $signed(CLOUD_BW'({s2_d_q, {MUL{1'b0}}}));

  logic                       out_valid_q, out_pv_q, out_end_q;
  logic signed [CLOUD_BW-1:0] out_x_q, out_y_q, out_z_q;
  logic [H_SIZE_BW-1:0]       out_u_q;
  logic [V_SIZE_BW-1:0]       out_v_q;

  // Stage 3: register the scaled, saturated coordinates and the beat sideband.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_pv_q    <= 1'b0;
      out_end_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_u_q     <= '0;
      out_v_q     <= '0;
    end else if (pipe_en) begin
      out_valid_q <= s2_valid_q;
      out_pv_q    <= s2_valid_q & ~s2_bad_q;
      out_end_q   <= s2_end_q;
      out_x_q     <= x_d;
      out_y_q     <= y_d;
      out_z_q     <= z_d;
      out_u_q     <= s2_u_q;
      out_v_q     <= s2_v_q;
    end
  end

  assign o_valid       = out_valid_q;
  assign o_point_valid = out_pv_q;
  assign o_frame_end   = out_end_q;
  assign o_cloud_x     = out_x_q;
  assign o_cloud_y     = out_y_q;
  assign o_cloud_z     = out_z_q;
  assign o_idx_x       = out_u_q;
  assign o_idx_y       = out_v_q;

endmodule

// File: tb/tb_back_proj.sv
// tb_back_proj: self-checking bench for back_proj.
// It uses a table of hand-computed vectors, hand-written multi-cycle sequences,
// and a scoreboard queue that is popped as output beats are handed off.
`timescale 1ns/1ps
module tb_back_proj;

  localparam int H_SIZE_BW = 10;
  localparam int V_SIZE_BW = 9;
  localparam int DEPTH_BW  = 16;
  localparam int MUL       = 8;
  localparam int INV_BW    = 24;
  localparam int CLOUD_BW  = 32;

  logic                       i_clk = 1'b0;
  logic                       i_rst_n = 1'b0;
  logic                       i_valid = 1'b0;
  logic                       i_frame_start = 1'b0;
  logic [DEPTH_BW-1:0]        i_depth = '0;
  logic                       o_ready;
  logic [H_SIZE_BW-1:0]       r_width = 10'd640;
  logic [V_SIZE_BW-1:0]       r_height = 9'd480;
  logic [H_SIZE_BW+MUL-1:0]   r_cx = 18'(320 << 8);
  logic [V_SIZE_BW+MUL-1:0]   r_cy = 17'(240 << 8);
  logic [INV_BW-1:0]          r_inv_fx = 24'(1 << 15);
  logic [INV_BW-1:0]          r_inv_fy = 24'(1 << 15);
`ifdef BACK_PROJ_DEPTH_RANGE_EN
  logic [DEPTH_BW-1:0]        r_depth_min = 16'd0;
  logic [DEPTH_BW-1:0]        r_depth_max = 16'hFFFF;
`endif
  logic                       i_ready = 1'b1;
  logic                       o_valid;
  logic                       o_point_valid;
  logic signed [CLOUD_BW-1:0] o_cloud_x, o_cloud_y, o_cloud_z;
  logic [H_SIZE_BW-1:0]       o_idx_x;
  logic [V_SIZE_BW-1:0]       o_idx_y;
  logic                       o_frame_end;

  back_proj dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_frame_start (i_frame_start),
    .i_depth       (i_depth),
    .o_ready       (o_ready),
    .r_width       (r_width),
    .r_height      (r_height),
    .r_cx          (r_cx),
    .r_cy          (r_cy),
    .r_inv_fx      (r_inv_fx),
    .r_inv_fy      (r_inv_fy),
`ifdef BACK_PROJ_DEPTH_RANGE_EN
    .r_depth_min   (r_depth_min),
    .r_depth_max   (r_depth_max),
`endif
    .i_ready       (i_ready),
    .o_valid       (o_valid),
    .o_point_valid (o_point_valid),
    .o_cloud_x     (o_cloud_x),
    .o_cloud_y     (o_cloud_y),
    .o_cloud_z     (o_cloud_z),
    .o_idx_x       (o_idx_x),
    .o_idx_y       (o_idx_y),
    .o_frame_end   (o_frame_end)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic   pv;
    longint x;
    longint y;
    longint z;
    int     u;
    int     v;
    logic   fe;
  } exp_t;

  typedef struct {
    logic        fs;
    logic [15:0] d;
    exp_t        e;
  } vec_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     beats = 0;
  int     ends = 0;
  int     bu = 0;
  int     bv = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat64(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Reference pinhole model with saturation and the invalid-depth rule.
  function automatic exp_t make_exp(input int u, input int v, input int d);
    exp_t e;
    logic bad;
    bad = (d == 0);
`ifdef BACK_PROJ_DEPTH_RANGE_EN
    bad = bad || (d < int'(r_depth_min)) || (d > int'(r_depth_max));
`endif
    e.u  = u;
    e.v  = v;
    e.fe = (u == int'(r_width) - 1) && (v == int'(r_height) - 1);
    if (bad) begin
      e.pv = 1'b0; e.x = 0; e.y = 0; e.z = 0;
    end else begin
      e.pv = 1'b1;
      e.x  = sat64(((longint'(u) * 256 - longint'(r_cx)) * longint'(d) * longint'(r_inv_fx)) >>> 24);
      e.y  = sat64(((longint'(v) * 256 - longint'(r_cy)) * longint'(d) * longint'(r_inv_fy)) >>> 24);
      e.z  = longint'(d) * 256;
    end
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic fs, input int d, input int u, input int v,
                                  input logic pv, input longint x, input longint y, input longint z);
    vec_t t;
    t.fs = fs; t.d = 16'(d);
    t.e.u = u; t.e.v = v; t.e.pv = pv; t.e.x = x; t.e.y = y; t.e.z = z; t.e.fe = 1'b0;
    return t;
  endfunction

  // Present one beat with its expected result, wait for the accepting edge, then advance the raster model.
  task automatic drive_beat(input logic fs, input logic [15:0] d, input exp_t e);
    int pu, pv;
    i_valid = 1'b1; i_frame_start = fs; i_depth = d; i_ready = 1'b1;
    sb.push_back(e);
    @(posedge i_clk); #1;
    pu = fs ? 0 : bu;
    pv = fs ? 0 : bv;
    if (pu == int'(r_width) - 1) begin
      bu = 0;
      bv = (pv == int'(r_height) - 1) ? 0 : pv + 1;
    end else begin
      bu = pu + 1;
      bv = pv;
    end
  endtask

  task automatic send(input logic fs, input logic [15:0] d);
    drive_beat(fs, d, make_exp(fs ? 0 : bu, fs ? 0 : bv, int'(d)));
  endtask

  task automatic idle();
    i_valid = 1'b0; i_frame_start = 1'b0; i_ready = 1'b1;
  endtask

  task automatic drain(input string name);
    idle();
    for (int i = 0; i < 16 && sb.size() > 0; i++) begin
      @(posedge i_clk); #1;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Compare every output beat that is handed off (o_valid & i_ready) with the scoreboard head.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      beats++;
      if (o_frame_end) ends++;
      if (sb.size() == 0) begin
        check("unexpected beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("beat x",     longint'(o_cloud_x), mon_e.x);
        check("beat y",     longint'(o_cloud_y), mon_e.y);
        check("beat z",     longint'(o_cloud_z), mon_e.z);
        check("beat pv",    longint'(o_point_valid), longint'(mon_e.pv));
        check("beat idx_x", longint'(o_idx_x), longint'(mon_e.u));
        check("beat idx_y", longint'(o_idx_y), longint'(mon_e.v));
        check("beat fend",  longint'(o_frame_end), longint'(mon_e.fe));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];
  exp_t e;
  int   beats0, ends0;

  initial begin
    tbl[0] = mk_vec(1'b1, 1024,  0, 0, 1'b1, -163840,   -122880, 262144);
    tbl[1] = mk_vec(1'b0, 3,     1, 0, 1'b1, -479,      -360,    768);
    tbl[2] = mk_vec(1'b0, 0,     2, 0, 1'b0, 0,         0,       0);
    tbl[3] = mk_vec(1'b0, 65535, 3, 0, 1'b1, -10387298, -7864200, 16776960);
    tbl[4] = mk_vec(1'b0, 7,     4, 0, 1'b1, -1106,     -840,    1792);
    tbl[5] = mk_vec(1'b0, 1000,  5, 0, 1'b1, -157500,   -120000, 256000);
    tbl[6] = mk_vec(1'b1, 2,     0, 0, 1'b1, -320,      -240,    512);
    tbl[7] = mk_vec(1'b0, 512,   1, 0, 1'b1, -81664,    -61440,  131072);

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst o_valid", o_valid, 0);
    check("rst o_point_valid", o_point_valid, 0);
    check("rst o_cloud_x", o_cloud_x, 0);
    check("rst o_cloud_y", o_cloud_y, 0);
    check("rst o_cloud_z", o_cloud_z, 0);
    check("rst o_idx_x", o_idx_x, 0);
    check("rst o_idx_y", o_idx_y, 0);
    check("rst o_frame_end", o_frame_end, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // First beat: latency of three enabled cycles, with the reference values.
    send(1'b1, 16'd1024);
    idle();
    check("lat edge0 o_valid", o_valid, 0);
    @(posedge i_clk); #1;
    check("lat edge1 o_valid", o_valid, 0);
    @(posedge i_clk); #1;
    check("lat edge2 o_valid", o_valid, 1);
    check("first x", o_cloud_x, -(640 << 8));
    check("first y", o_cloud_y, -(480 << 8));
    check("first z", o_cloud_z, 1024 << 8);
    check("first pv", o_point_valid, 1);
    drain("drain first");

    // Table vectors streamed back to back.
    for (int i = 0; i < 8; i++) drive_beat(tbl[i].fs, tbl[i].d, tbl[i].e);
    drain("drain table");

    // Stall with three beats in flight: outputs freeze on the oldest beat.
    send(1'b0, 16'd50);
    send(1'b0, 16'd60);
    send(1'b0, 16'd70);
    i_valid = 1'b1; i_depth = 16'd99; i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall o_ready", o_ready, 0);
      check("stall o_valid", o_valid, 1);
      if (sb.size() == 0) begin
        check("stall queue", 0, 1);
      end else begin
        check("stall x", o_cloud_x, sb[0].x);
        check("stall idx_x", o_idx_x, sb[0].u);
      end
      @(posedge i_clk); #1;
    end
    drain("drain stall");

    // Saturation at both ends with the maximum reciprocal.
    r_inv_fx = 24'hFFFFFF;
    e = make_exp(0, 0, 65535);
    e.x = -64'sd2147483648;
    drive_beat(1'b1, 16'd65535, e);
    while (bu != 639) send(1'b0, 16'd1);
    e = make_exp(639, 0, 65535);
    e.x = 64'sd2147483647;
    drive_beat(1'b0, 16'd65535, e);
    drain("drain sat");
    r_inv_fx = 24'(1 << 15);

    // Mid-frame frame_start at pixel 100 of row 3, with idle gaps on the way.
    send(1'b1, 16'd1000);
    while (!(bu == 100 && bv == 3)) begin
      if ((bu % 50) == 7) begin
        idle();
        @(posedge i_clk); #1;
      end
      send(1'b0, 16'(bu * 37 + bv + 1));
    end
    e = make_exp(0, 0, 777);
    e.u = 0; e.v = 0;
    drive_beat(1'b1, 16'd777, e);
    e = make_exp(1, 0, 5);
    drive_beat(1'b0, 16'd5, e);
    drain("drain resync");

    // A full small frame: count the beats, check frame_end and the wrap back to (0,0).
    r_width = 10'd16; r_height = 9'd8;
    beats0 = beats; ends0 = ends;
    send(1'b1, 16'd1);
    repeat (127) send(1'b0, 16'd1);
    e = make_exp(0, 0, 1);
    drive_beat(1'b0, 16'd1, e);
    drain("drain frame");
    check("frame beats", beats - beats0, 16 * 8 + 1);
    check("frame ends", ends - ends0, 1);

    // Zero depth at (5,7): the beat is still emitted, with zero coordinates.
    while (!(bu == 5 && bv == 7)) send(1'b0, 16'd2);
    e.u = 5; e.v = 7; e.pv = 1'b0; e.x = 0; e.y = 0; e.z = 0; e.fe = 1'b0;
    drive_beat(1'b0, 16'd0, e);
    drain("drain zero");

    // Reset mid-frame: the pipeline is flushed and the raster returns to (0,0).
    r_width = 10'd640; r_height = 9'd480;
    send(1'b1, 16'd10);
    send(1'b0, 16'd20);
    send(1'b0, 16'd30);
    i_rst_n = 1'b0;
    #1;
    check("midrst o_valid", o_valid, 0);
    check("midrst o_cloud_x", o_cloud_x, 0);
    sb.delete();
    bu = 0; bv = 0;
    idle();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    e = make_exp(0, 0, 40);
    drive_beat(1'b0, 16'd40, e);
    drain("drain midrst");

`ifdef BACK_PROJ_DEPTH_RANGE_EN
    // Depth range window [100, 4000].
    r_depth_min = 16'd100; r_depth_max = 16'd4000;
    e = make_exp(bu, bv, 99);   e.pv = 1'b0; e.x = 0; e.y = 0; e.z = 0;
    drive_beat(1'b0, 16'd99, e);
    e = make_exp(bu, bv, 4001); e.pv = 1'b0; e.x = 0; e.y = 0; e.z = 0;
    drive_beat(1'b0, 16'd4001, e);
    e = make_exp(bu, bv, 100);  e.pv = 1'b1;
    drive_beat(1'b0, 16'd100, e);
    e = make_exp(bu, bv, 4000); e.pv = 1'b1;
    drive_beat(1'b0, 16'd4000, e);
    drain("drain range");
    r_depth_min = 16'd0; r_depth_max = 16'hFFFF;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
